// File: rtl/f_pow_pkg.sv
// Shared caller-side definitions: FSM state encoding and callee operation codes.
// Every block that calls a function over start/done reuses these.
package f_pow_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LATCH   = 3'd1,
    STEP    = 3'd2,
    CALL    = 3'd3,
    WAIT_LO = 3'd4,
    WAIT_HI = 3'd5,
    FINISH  = 3'd6
  } state_t;

  typedef enum logic {
    MUL = 1'b0,
    SQ  = 1'b1
  } op_t;

endpackage

// File: rtl/f_pow_if.sv
// Upstream callee-style port of f_pow, and the caller-to-callee start/done port.
// master drives the request side, slave drives the completion side.
interface f_pow_if #(
  parameter int W     = 32,
  parameter int EXP_W = 32
);
  logic             start;
  logic [W-1:0]     a;
  logic [EXP_W-1:0] b;
  logic [W-1:0]     result;
  logic             done;

  modport master (output start, a, b, input result, done);
  modport slave  (input start, a, b, output result, done);
endinterface

interface f_pow_call_if #(
  parameter int W = 32
);
  logic         call_start;
  logic [W-1:0] call_a;
  logic [W-1:0] call_b;
  logic [W-1:0] call_result;
  logic         call_done;

  modport master (output call_start, call_a, call_b, input call_result, call_done);
  modport slave  (input call_start, call_a, call_b, output call_result, call_done);
endinterface

// File: rtl/f_pow_call_master.sv
// Generic caller handshake: registers operands on req, pulses call_start once,
// waits for call_done low then high, and acks with the callee's return value.
module f_pow_call_master
  import f_pow_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         ack,
  output logic [W-1:0] ret,
  f_pow_call_if.master cif
);

  state_t       state, state_nxt;
  logic [W-1:0] x_q, y_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operands load only on acceptance, so they stay frozen for the whole call.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (state == IDLE && req) begin
      x_q <= x;
      y_q <= y;
    end
  end

  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    case (state)
      IDLE:    if (req) state_nxt = CALL;
      CALL:    state_nxt = WAIT_LO;
      // A done still high from the callee's idle state must not end the call.
      WAIT_LO: if (!cif.call_done) state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (cif.call_done) begin
          ack       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ret            = cif.call_result;
  assign cif.call_start = (state == CALL);
  assign cif.call_a     = x_q;
  assign cif.call_b     = y_q;

endmodule

// File: rtl/f_pow.sv
// result = a ** b mod 2^W by square-and-multiply, each product delegated to a
// multiplier callee; exposes a start/done callee-style port upstream.
module f_pow
  import f_pow_pkg::*;
#(
  parameter int W     = 32,
  parameter int EXP_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  f_pow_if.slave       up,
  f_pow_call_if.master cif
);

  state_t           state, state_nxt;
  logic [W-1:0]     r, p, result_q;
  logic [EXP_W-1:0] e;
  logic             mul_done, done_q;
  op_t              op;

  logic             req, ack, take_mul, take_sq;
  logic [W-1:0]     x, y, ret;

  assign take_mul = e[0] && !mul_done;
  assign take_sq  = (e >> 1) != '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    x         = '0;
    y         = '0;
    case (state)
      IDLE:  if (up.start) state_nxt = LATCH;
      LATCH: state_nxt = STEP;
      STEP: begin
        if (e == '0) begin
          state_nxt = FINISH;
        end else if (take_mul) begin
          req       = 1'b1;
          x         = r;
          y         = p;
          state_nxt = CALL;
        end else if (take_sq) begin
          req       = 1'b1;
          x         = p;
          y         = p;
          state_nxt = CALL;
        end else begin
          state_nxt = FINISH;
        end
      end
      // CALL covers the whole call_master round trip until its ack.
      CALL:    if (ack) state_nxt = STEP;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r        <= '0;
      p        <= '0;
      e        <= '0;
      mul_done <= 1'b0;
      op       <= MUL;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: done_q <= !up.start;
        LATCH: begin
          r        <= W'(1);
          p        <= up.a;
          e        <= up.b;
          mul_done <= 1'b0;
        end
        STEP: begin
          // Without a call the exponent is exhausted; clearing it is a no-op when already 0.
          if (req) op <= take_mul ? MUL : SQ;
          else     e  <= '0;
        end
        CALL: begin
          if (ack) begin
            if (op == MUL) begin
              r        <= ret;
              mul_done <= 1'b1;
            end else begin
              p        <= ret;
              e        <= e >> 1;
              mul_done <= 1'b0;
            end
          end
        end
        FINISH: begin
          result_q <= r;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign up.result = result_q;
  assign up.done   = done_q;

  f_pow_call_master #(.W(W)) u_call (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .x     (x),
    .y     (y),
    .ack   (ack),
    .ret   (ret),
    .cif   (cif)
  );

endmodule

// File: tb/tb_f_pow.sv
// Bench for f_pow with a behavioural multiplier callee of configurable delay.
module tb_f_pow;

  logic clk;
  logic reset;

  f_pow_if #(.W(32), .EXP_W(32)) up ();
  f_pow_call_if #(.W(32)) cif ();

  f_pow #(.W(32), .EXP_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .up    (up),
    .cif   (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Callee: idle holds done=1, samples operands one cycle after start.
  int          cdelay = 0;
  int          cst;
  int          cnt;
  logic [31:0] ca, cb, cres;
  logic        cdone;

  assign cif.call_result = cres;
  assign cif.call_done   = cdone;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cst   <= 0;
      cnt   <= 0;
      cdone <= 1'b0;
      cres  <= '0;
      ca    <= '0;
      cb    <= '0;
    end else begin
      case (cst)
        0: begin
          cdone <= 1'b1;
          if (cif.call_start) begin
            cst   <= 1;
            cdone <= 1'b0;
          end
        end
        1: begin
          ca  <= cif.call_a;
          cb  <= cif.call_b;
          cnt <= cdelay;
          cst <= 2;
        end
        default: begin
          if (cnt == 0) begin
            cres  <= ca * cb;
            cdone <= 1'b1;
            cst   <= 0;
          end else begin
            cnt <= cnt - 1;
          end
        end
      endcase
    end
  end

  // Protocol monitor: pulse count, back-to-back pulses, operand stability per call.
  int          pulses   = 0;
  int          dbl      = 0;
  int          unstable = 0;
  logic        prev_cs  = 1'b0;
  int          phase    = 0;
  logic [31:0] ha, hb;

  always @(posedge clk) begin
    prev_cs <= cif.call_start;
    if (!reset) begin
      phase <= 0;
    end else if (cif.call_start) begin
      pulses <= pulses + 1;
      if (prev_cs) dbl <= dbl + 1;
      ha    <= cif.call_a;
      hb    <= cif.call_b;
      phase <= 1;
    end else if (phase != 0) begin
      if (cif.call_a !== ha || cif.call_b !== hb) unstable <= unstable + 1;
      if (phase == 1 && !cif.call_done) phase <= 2;
      if (phase == 2 && cif.call_done)  phase <= 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_pow(input logic [31:0] ba, input logic [31:0] ex);
    logic [31:0] acc;
    acc = 32'd1;
    for (int i = 0; i < int'(ex); i++) acc = acc * ba;
    return acc;
  endfunction

  function automatic int ref_calls(input logic [31:0] ex);
    int hi;
    if (ex == 0) return 0;
    hi = 0;
    for (int i = 0; i < 32; i++) if (ex[i]) hi = i;
    return $countones(ex) + hi;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (up.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_done", 64'(up.done), 64'd1);
  endtask

  // lat counts active edges from the one that samples start to the one raising done.
  task automatic run(input logic [31:0] ra, input logic [31:0] rb, input int hold,
                     output logic [31:0] res, output int ncalls, output int lat);
    int base;
    int bad;
    wait_idle();
    base     = pulses;
    bad      = 0;
    up.a     = ra;
    up.b     = rb;
    up.start = 1'b1;
    @(negedge clk);
    lat = 0;
    for (int i = 1; i < hold; i++) begin
      if (up.done !== 1'b0) bad++;
      @(negedge clk);
      lat++;
    end
    up.start = 1'b0;
    if (hold > 1) check("done_low_while_start_held", 64'(bad), 64'd0);
    while (up.done !== 1'b1 && lat < 20000) begin
      @(negedge clk);
      lat++;
    end
    if (up.done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: done=%b after %0d cycles, required 1", up.done, lat);
    end
    res    = up.result;
    ncalls = pulses - base;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[10];
  logic [31:0] res, ra, rb;
  int          ncalls, lat, base;

  initial begin
    tbl[0] = '{32'd3,          32'd5,    32'd243};
    tbl[1] = '{32'd0,          32'd0,    32'd1};
    tbl[2] = '{32'd2,          32'd32,   32'd0};
    tbl[3] = '{32'hFFFF_FFFF,  32'd3,    32'hFFFF_FFFF};
    tbl[4] = '{32'd7,          32'd0,    32'd1};
    tbl[5] = '{32'd0,          32'd5,    32'd0};
    tbl[6] = '{32'd1,          32'd1000, 32'd1};
    tbl[7] = '{32'd2,          32'd31,   32'h8000_0000};
    tbl[8] = '{32'd10,         32'd9,    32'h3B9A_CA00};
    tbl[9] = '{32'h0001_0001,  32'd2,    32'h0002_0001};

    up.start = 1'b0;
    up.a     = '0;
    up.b     = '0;
    reset    = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("reset_done",       64'(up.done),        64'd0);
    check("reset_result",     64'(up.result),      64'd0);
    check("reset_call_start", 64'(cif.call_start), 64'd0);
    check("reset_call_a",     64'(cif.call_a),     64'd0);
    check("reset_call_b",     64'(cif.call_b),     64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run(tbl[i].a, tbl[i].b, 1, res, ncalls, lat);
      check($sformatf("vec%0d_result", i), 64'(res), 64'(tbl[i].exp));
      check($sformatf("vec%0d_calls", i), 64'(ncalls), 64'(ref_calls(tbl[i].b)));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(3 + 5 * ref_calls(tbl[i].b)));
    end

    for (int i = 0; i < 25; i++) begin
      ra     = $urandom;
      rb     = $urandom_range(0, 200);
      cdelay = $urandom_range(0, 3);
      run(ra, rb, 1, res, ncalls, lat);
      check($sformatf("rand%0d_result", i), 64'(res), 64'(ref_pow(ra, rb)));
      check($sformatf("rand%0d_calls", i), 64'(ncalls), 64'(ref_calls(rb)));
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'(3 + (5 + cdelay) * ref_calls(rb)));
    end

    // Slow callee: done rise delayed 10 cycles, operands must stay put.
    cdelay = 10;
    run(32'd12345, 32'd13, 1, res, ncalls, lat);
    check("slow_result",  64'(res),    64'(ref_pow(32'd12345, 32'd13)));
    check("slow_calls",   64'(ncalls), 64'(ref_calls(32'd13)));
    check("slow_latency", 64'(lat),    64'(3 + 15 * ref_calls(32'd13)));

    // start held for 20 cycles: one computation only.
    cdelay = 0;
    run(32'd3, 32'd5, 20, res, ncalls, lat);
    check("held_result", 64'(res),    64'd243);
    check("held_calls",  64'(ncalls), 64'd4);
    base = pulses;
    repeat (6) @(negedge clk);
    check("held_no_restart_calls", 64'(pulses - base), 64'd0);
    check("held_done_stays",       64'(up.done),       64'd1);

    // Reset while the caller waits in WAIT_HI for a slow callee.
    cdelay   = 10;
    up.a     = 32'd7;
    up.b     = 32'd3;
    up.start = 1'b1;
    @(negedge clk);
    up.start = 1'b0;
    lat = 0;
    while (cif.call_start !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("midcall_pulse_seen", 64'(cif.call_start), 64'd1);
    repeat (5) @(negedge clk);
    check("midcall_call_b", 64'(cif.call_b), 64'd7);
    reset = 1'b0;
    #1;
    check("midreset_result",     64'(up.result),      64'd0);
    check("midreset_done",       64'(up.done),        64'd0);
    check("midreset_call_start", 64'(cif.call_start), 64'd0);
    check("midreset_call_a",     64'(cif.call_a),     64'd0);
    check("midreset_call_b",     64'(cif.call_b),     64'd0);
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    cdelay = 0;
    run(32'd5, 32'd2, 1, res, ncalls, lat);
    check("after_reset_result", 64'(res),    64'd25);
    check("after_reset_calls",  64'(ncalls), 64'd2);

    check("operands_stable",       64'(unstable), 64'd0);
    check("no_back_to_back_start", 64'(dbl),      64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/f_pow.md
# f_pow

Caller-side block for the start/done function-call protocol. It computes `result = a ** b` (mod 2^32) by square-and-multiply, issuing each multiplication as a call to a 32-bit multiplier callee over the same start/done handshake. Upstream, it exposes a callee-style start/done interface, so it is itself callable. It sits between a top-level controller and a multiplier function block.

## Interface
- `W`, default 32: data width of base, result and callee operands.
- `EXP_W`, default 32: exponent width.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low (0 = reset).
- `start`  input  1  upstream call request, sampled in IDLE.
- `a`  input  W  base, captured in LATCH.
- `b`  input  EXP_W  exponent, captured in LATCH.
- `result`  output  W  a**b mod 2^W; valid while `done`=1.
- `done`  output  1  upstream completion/idle flag.
- `call_start`  output  1  callee request, a one-cycle pulse.
- `call_a`, `call_b`  output  W  callee operands, registered and held.
- `call_result`  input  W  callee return value.
- `call_done`  input  1  callee completion flag.

## Operation
- Registers: `r` (accumulator), `p` (running power), `e` (remaining exponent), `mul_done` (bit-0 multiply already applied), `op` (MUL or SQ).
- **IDLE**: `done <= start ? 0 : 1`; if `start`, go to LATCH.
- **LATCH**: set `r <= 1`, `p <= a`, `e <= b`, `mul_done <= 0`; go to STEP.
- **STEP**: evaluate in this order:
  - `e==0` -> FINISH.
  - `e[0] && !mul_done` -> set `op=MUL`, `call_a<=r`, `call_b<=p`; go to CALL.
  - `(e>>1)!=0` -> set `op=SQ`, `call_a<=p`, `call_b<=p`; go to CALL.
  - otherwise -> `e<=0`, go to FINISH.
- **CALL**: `call_start=1` for exactly this cycle; go to WAIT_LO.
- **WAIT_LO**: wait for `call_done==0`, then go to WAIT_HI.
- **WAIT_HI**: wait for `call_done==1`, then capture `call_result`:
  - MUL: `r<=call_result`, `mul_done<=1`.
  - SQ: `p<=call_result`, `e<=e>>1`, `mul_done<=0`.
  - Then go to STEP.
- **FINISH**: `result<=r`, `done<=1`; go to IDLE.
- Arithmetic: every product is truncated to the low W bits. No overflow flag.
- `b==0` gives result 1 with zero callee calls, for any `a`, including 0.
- `call_a` and `call_b` are held unchanged from STEP until WAIT_HI exits. The callee samples its operands one cycle after it sees start.
- `start` is ignored outside IDLE.
- Reset (async, active-low): state=IDLE; `result`, `done`, `call_start`, `call_a`, `call_b`, `r`, `p`, `e`, `mul_done` all cleared to 0. Reset mid-call abandons the call. The callee is reset by the same net.

## Timing
- Upstream: start is sampled at edge t in IDLE. `done` falls after edge t.
- For `b==0`: LATCH at t+1, STEP at t+2, FINISH at t+3. `done`=1 and `result` are visible after edge t+3.
- Each call costs STEP + CALL + WAIT_LO + WAIT_HI dwell. With a 3-state multiplier callee this is 5 cycles per call.
- Call count is popcount(b) + floor(log2 b).
- WAIT_LO guards against a stale `call_done`=1 from the callee's idle state. WAIT_LO never exits on `call_done`=1.
- `call_start` is never high in two consecutive cycles.

## Structure
- Shared package: state encoding (IDLE, LATCH, STEP, CALL, WAIT_LO, WAIT_HI, FINISH) and op codes (MUL, SQ). Every caller-side block in the codebase reuses these.
- Optional sub-module `call_master` holds the CALL/WAIT_LO/WAIT_HI handshake and operand registers.
  - Interface toward `f_pow`: `req`, `x`, `y`, `ack`, `ret`.
  - It is reusable by every block that calls a function.

## Test plan
- `a`=3, `b`=5, with the multiplier callee attached -> `result`=243 (0xF3) and exactly 4 `call_start` pulses.
- `a`=0, `b`=0 -> `result`=1, no `call_start` pulse, `done` high 3 cycles after `start` is sampled.
- `a`=2, `b`=32 -> `result`=0 (wrap-around). `a`=0xFFFFFFFF, `b`=3 -> `result`=0xFFFFFFFF.
- Callee stub that delays `call_done` rise by 10 cycles and holds `call_done`=1 in idle -> correct `result`, with `call_a`/`call_b` stable throughout each wait.
- `start` held high for 20 cycles during a run -> only one computation; `done` is not re-raised until FINISH.
- `reset`=0 asserted while in WAIT_HI -> all outputs 0 immediately. After release, a new `a`=5, `b`=2 run returns 25.
